ksa: RTL and testbench
======================

Name: ksa

Overview:
- RC4 key-scheduling stage.
- Reads the 256-byte S memory, which already holds s[i]=i, and runs the RC4 KSA permutation in place using a byte-wise key.
- Sits directly upstream of the PRGA stage: when this block reasserts rdy, S is fully permuted and the PRGA may be enabled with the same key.
- Shares the S memory port with the init and PRGA stages. The top level muxes that port by which block is busy.

Parameters:
KEY_BYTES, 3, number of key bytes; key port width is 8*KEY_BYTES.
S_LEN, 256, number of S entries; fixed at 256 (8-bit index arithmetic).

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  reset; asynchronous, active-low
en  input  1  start request; sampled only while rdy=1
rdy  output  1  high when idle and able to accept en
key  input  8*KEY_BYTES  cipher key; most-significant byte is key byte 0
addr  output  8  S memory address
rddata  input  8  S memory read data; valid one cycle after addr is presented
wrdata  output  8  S memory write data
wren  output  1  S memory write enable

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, i=0, j=0, latched key=0, si/sj regs=0.
  - rdy=1, addr=0, wrdata=0, wren=0.
  - Reset mid-operation aborts immediately; partially permuted S is left as-is.
- Output default: addr, wrdata and wren are 0 in every state not listed below as driving them.
- Handshake:
  - In IDLE with rdy=1, en=1 at a rising edge latches key, clears i and j, and moves to READ_SI.
  - rdy drops the cycle after acceptance.
  - en while rdy=0 is ignored.
  - en held high after completion starts a new run.
- FSM, one iteration per i (rdy=0 in all states except IDLE):
  - READ_SI: addr=i.
  - WAIT_SI: addr=i; si<=rddata at exit.
  - CALC_J: j<=(j+si+kb) mod 256, where kb=key byte (i mod KEY_BYTES).
  - READ_SJ: addr=j.
  - WAIT_SJ: addr=j; sj<=rddata at exit.
  - WRITE_SJ: addr=j, wrdata=si, wren=1.
  - WRITE_SI: addr=i, wrdata=sj, wren=1.
  - INC_I: if i==255 go to IDLE, else i<=i+1 and go to READ_SI.
- Key byte select: byte k = key[8*(KEY_BYTES-1-k) +: 8]. For 24-bit key 24'h1A2B3C: i=0 uses 0x1A, i=1 uses 0x2B, i=2 uses 0x3C, i=3 uses 0x1A again.
- Arithmetic: j and the sum are 8-bit and wrap mod 256. i mod KEY_BYTES is tracked by a small counter that wraps at KEY_BYTES; no divider.
- i==j case: both writes hit the same address. WRITE_SI occurs last, so s[i] keeps its value (sj==si); this is correct.
- Latency: 8 cycles per iteration. rdy=1 again after exactly 1+256*8 = 2049 rising edges from the accepting edge (without the optional feature).
- Termination: i must not wrap past 255; exactly 256 iterations run.

Optional Feature:
- Macro: KSA_INIT_EN.
- Defined:
  - Block first runs an INIT state for 256 cycles: addr=n, wrdata=n, wren=1 for n=0..255, then enters READ_SI with i=j=0.
  - Latency becomes 2305 edges.
  - The separate init stage is no longer required.
- Undefined: no INIT state; S must already hold identity.

Decomposition:
- Package rc4_pkg holds:
  - ksa_state_t enum: IDLE, INIT, READ_SI, WAIT_SI, CALC_J, READ_SJ, WAIT_SJ, WRITE_SJ, WRITE_SI, INC_I.
  - localparam S_LEN=256.
  - Function key_byte(key, idx) used by both KSA and any key-search logic.
- No sub-module; FSM plus datapath is a single module.

Test Plan:
- Reset then idle: rst_n pulse -> rdy=1, addr=0, wrdata=0, wren=0; en=0 held 10 cycles -> no change.
- First iteration, key=24'h1A2B3C, memory model returns rddata=addr (identity):
  - READ_SI addr=0.
  - READ_SJ addr=0x1A.
  - WRITE_SJ addr=0x1A, wrdata=0x00, wren=1.
  - WRITE_SI addr=0x00, wrdata=0x1A, wren=1.
- Key cycling, full run against a behavioural RC4 reference model with key=24'h000311:
  - Final 256-byte S matches the model.
  - rdy reasserts on edge 2049; i=3 uses key byte 0x00.
- i==j and wrap: key=24'h000000 with identity S:
  - i=0: j=0; both writes to addr 0 with wrdata 0.
  - i=1: j=1.
  - Confirm j wraps mod 256 late in the run (e.g. j=0xFF+0x02 -> 0x01).
- Mid-run reset and busy-enable:
  - Toggle en during iteration 5 -> ignored.
  - Assert rst_n=0 asynchronously (between clock edges) during WRITE_SJ -> wren drops immediately, rdy=1, then a new en restarts at READ_SI addr=0.
- With KSA_INIT_EN: first 256 cycles after en show addr=wrdata=n with wren=1; final S matches the model; rdy reasserts on edge 2305.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: KSA state encoding, S-box length and key byte selection.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    READ_SI,
    WAIT_SI,
    CALC_J,
    READ_SJ,
    WAIT_SJ,
    WRITE_SJ,
    WRITE_SI,
    INC_I
  } ksa_state_t;

  localparam int S_LEN         = 256;
  localparam int KEY_MAX_BYTES = 32;
  localparam int KEY_MAX_W     = 8 * KEY_MAX_BYTES;

  // Byte 0 is the most-significant byte of a key_bytes-wide key held in the low bits.
  function automatic logic [7:0] key_byte(input logic [KEY_MAX_W-1:0] key,
                                          input int unsigned          key_bytes,
                                          input int unsigned          idx);
    logic [KEY_MAX_W-1:0] sh;
    sh = key >> (8 * (key_bytes - 1 - idx));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes the shared S memory in place using the latched key.
// Define KSA_INIT_EN to fill S with the identity permutation before scheduling.
module ksa
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  localparam int KI_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  ksa_state_t             state, state_nx;
  logic [7:0]             i_q, j_q, si_q, sj_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [KI_W-1:0]        kidx_q;
  logic [7:0]             kb;
  logic                   accept;

  assign accept = (state == IDLE) && en;
  assign kb     = key_byte(KEY_MAX_W'(key_q), KEY_BYTES, 32'(kidx_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    addr     = 8'd0;
    wrdata   = 8'd0;
    wren     = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
`ifdef KSA_INIT_EN
          state_nx = INIT;
`else
          state_nx = READ_SI;
`endif
        end
      end
`ifdef KSA_INIT_EN
      INIT: begin
        addr   = i_q;
        wrdata = i_q;
        wren   = 1'b1;
        if (i_q == 8'd255) state_nx = READ_SI;
      end
`endif
      READ_SI: begin
        addr     = i_q;
        state_nx = WAIT_SI;
      end
      WAIT_SI: begin
        addr     = i_q;
        state_nx = CALC_J;
      end
      CALC_J:  state_nx = READ_SJ;
      READ_SJ: begin
        addr     = j_q;
        state_nx = WAIT_SJ;
      end
      WAIT_SJ: begin
        addr     = j_q;
        state_nx = WRITE_SJ;
      end
      WRITE_SJ: begin
        addr     = j_q;
        wrdata   = si_q;
        wren     = 1'b1;
        state_nx = WRITE_SI;
      end
      // Issued last so that when i==j the location ends up holding its original value.
      WRITE_SI: begin
        addr     = i_q;
        wrdata   = sj_q;
        wren     = 1'b1;
        state_nx = INC_I;
      end
      INC_I:   state_nx = (i_q == 8'd255) ? IDLE : READ_SI;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q    <= 8'd0;
      j_q    <= 8'd0;
      si_q   <= 8'd0;
      sj_q   <= 8'd0;
      key_q  <= '0;
      kidx_q <= '0;
    end else begin
      if (accept) begin
        key_q  <= key;
        i_q    <= 8'd0;
        j_q    <= 8'd0;
        kidx_q <= '0;
      end
      case (state)
        // The fill counter reuses i; it wraps to 0 exactly as scheduling begins.
        INIT:    i_q  <= i_q + 8'd1;
        WAIT_SI: si_q <= rddata;
        CALC_J:  j_q  <= j_q + si_q + kb;
        WAIT_SJ: sj_q <= rddata;
        INC_I: begin
          if (i_q != 8'd255) begin
            i_q    <= i_q + 8'd1;
            kidx_q <= (kidx_q == KI_W'(KEY_BYTES - 1)) ? '0 : kidx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa.sv
// Scoreboard bench for ksa: a reference RC4 schedule predicts every S write and the final S.
module tb_ksa;

`ifdef KSA_INIT_EN
  localparam int OFF = 256;
`else
  localparam int OFF = 0;
`endif
  localparam int LAT = 2049 + OFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr, rddata, wrdata;
  logic        wren;

  always #5 clk = ~clk;

  ksa #(.KEY_BYTES(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  // Synchronous S memory: one cycle read latency
  logic [7:0] mem [256];
  logic       mem_fill = 1'b0;
  logic       fill_inv = 1'b0;

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int n = 0; n < 256; n++) mem[n] <= fill_inv ? ~8'(n) : 8'(n);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  bit         mon_en = 1'b0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] ref_s [256];
  int         ref_j1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_extra: got write addr=0x%0h data=0x%0h, expected none", addr, wrdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 32'(addr), 32'(w.a));
        check("wr_data", 32'(wrdata), 32'(w.d));
      end
    end
  end

  // Plain RC4 KSA over an integer array, recording every write the block should issue
  task automatic model(input logic [23:0] k);
    int j, t, kb;
    exp_q.delete();
    if (OFF > 0)
      for (int n = 0; n < 256; n++) exp_q.push_back(wr_t'{a: 8'(n), d: 8'(n)});
    for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = int'((k >> (8 * (2 - (i % 3)))) & 24'hFF);
      j  = (j + int'(ref_s[i]) + kb) % 256;
      if (i == 0) ref_j1 = j;
      exp_q.push_back(wr_t'{a: 8'(j), d: ref_s[i]});
      exp_q.push_back(wr_t'{a: 8'(i), d: ref_s[j]});
      t        = int'(ref_s[i]);
      ref_s[i] = ref_s[j];
      ref_s[j] = 8'(t);
    end
  endtask

  task automatic fill_mem();
    @(negedge clk);
    mem_fill = 1'b1;
    fill_inv = (OFF > 0);
    @(posedge clk);
    #1 mem_fill = 1'b0;
  endtask

  task automatic run_ksa(input logic [23:0] k);
    int  edges, nmis;
    bit  done;
    fill_mem();
    model(k);
    mon_en = 1'b1;
    @(negedge clk);
    key = k;
    en  = 1'b1;
    check("rdy_idle", 32'(rdy), 32'd1);
    @(posedge clk);
    #1 en = 1'b0;
    edges = 1;
    done  = 1'b0;
    while (!done && edges < 2600) begin
      @(negedge clk);
      if (edges == 1) begin
        check("start_addr", 32'(addr), 32'd0);
        check("rdy_busy", 32'(rdy), 32'd0);
      end
      if (edges == 4 + OFF) check("read_sj_addr", 32'(addr), 32'(ref_j1));
      if (rdy) done = 1'b1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    if (!done) $display("FAIL timeout: rdy not seen after %0d edges, expected by %0d", edges, LAT);
    check("latency", 32'(edges), 32'(LAT));
    check("wr_remaining", 32'(exp_q.size()), 32'd0);
    nmis = 0;
    for (int n = 0; n < 256; n++) if (mem[n] !== ref_s[n]) nmis++;
    check("final_s", 32'(nmis), 32'd0);
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic midrun_reset(input logic [23:0] k);
    int edges;
    fill_mem();
    mon_en = 1'b0;
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    edges = 1;
    while (edges < 46 + OFF) begin
      @(negedge clk);
      en = (edges >= 41 + OFF && edges <= 44 + OFF);
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    en = 1'b0;
    check("busy_en_ignored", 32'(rdy), 32'd0);
    check("write_sj_wren", 32'(wren), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wren", 32'(wren), 32'd0);
    check("async_rst_rdy", 32'(rdy), 32'd1);
    check("async_rst_addr", 32'(addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    key   = 24'h0;
    #12;
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wrdata", 32'(wrdata), 32'd0);
    check("rst_wren", 32'(wren), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_hold", {21'd0, rdy, wren, wrdata, addr[7:0]} , {21'd0, 1'b1, 1'b0, 8'd0, 8'd0});
    end

    run_ksa(24'h1A2B3C);
    run_ksa(24'h000311);
    run_ksa(24'h000000);
    midrun_reset(24'($urandom));
    run_ksa(24'($urandom));
    run_ksa(24'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
